// File: rtl/rv32i_ctl_exec.sv
// rv32i_ctl_exec: control FSM, instruction decoder and ALU for the multicycle RV32I core.
//
// Each instruction takes four enabled cycles: FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// The decoder registers its fields at the end of DECODE. The ALU registers its result
// and compare flags at the end of EXECUTE. PC and rd are committed at the WRITEBACK edge.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-high reset (wins over ce)
//   ce                    clock enable; low freezes state, decoder and ALU registers
//   instr, pc             current IR and PC contents
//   rs1_val, rs2_val      register-file read data
//   fetch_en              load IR from memory (FETCH)
//   pc_inc, pc_in_sel     PC update strobe and source select (1: pc+4 / pc+imm, 0: jalr target)
//   branch_taken          take pc+imm
//   regfile_ce/_we        register-file enable / rd write strobe
//   rd_idx/rs1_idx/rs2_idx  decoded register indices
//   imm                   decoded sign-extended immediate
//   rs1_sel, rs2_sel      ALU operand selects (rs1_val/pc, rs2_val/imm)
//   rd_in_sel             rd source: 01 imm, 10 alu_result, 00 pc+4
//   alu_result, alu_flags registered ALU result and {ltu, lt, zero}
//   illegal               decoded opcode unsupported (instruction executes as a NOP)
//
// state     | meaning
// ----------+------------------------------------------------------
// FETCH     | IR load from memory
// DECODE    | decoder registers capture instr, register file read
// EXECUTE   | ALU registers capture result and flags
// WRITEBACK | PC update and optional rd write

module rv32i_ctl_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        fetch_en,
  output logic        pc_inc,
  output logic        pc_in_sel,
  output logic        branch_taken,
  output logic        regfile_ce,
  output logic        regfile_we,
  output logic [4:0]  rd_idx,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [31:0] imm,
  output logic        rs1_sel,
  output logic        rs2_sel,
  output logic [1:0]  rd_in_sel,
  output logic [31:0] alu_result,
  output logic [2:0]  alu_flags,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   dec_en;
  logic   alu_en;
  logic   writes_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_en   = 1'b0;
    pc_inc     = 1'b0;
    regfile_ce = 1'b0;
    regfile_we = 1'b0;
    dec_en     = 1'b0;
    alu_en     = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_en = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        dec_en     = 1'b1;
        regfile_ce = 1'b1;
        state_d    = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_en  = 1'b1;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        // Commit strobes are suppressed while reset is asserted so that an
        // aborted instruction never updates PC or rd on the reset edge.
        pc_inc     = ~reset;
        regfile_ce = 1'b1;
        regfile_we = writes_q & ~reset;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [31:0] imm_d;
  logic        rs1_sel_d, rs2_sel_d, writes_d, pc_in_sel_d;
  logic        is_branch_d, is_jal_d, illegal_d;
  logic [1:0]  rd_in_sel_d;
  alu_op_e     alu_op_d;

  logic        is_branch_q, is_jal_q;
  logic [2:0]  funct3_q;
  alu_op_e     alu_op_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    imm_d       = 32'b0;
    rs1_sel_d   = 1'b0;
    rs2_sel_d   = 1'b0;
    rd_in_sel_d = 2'b00;
    writes_d    = 1'b0;
    pc_in_sel_d = 1'b1;
    is_branch_d = 1'b0;
    is_jal_d    = 1'b0;
    illegal_d   = 1'b0;
    alu_op_d    = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        rs1_sel_d   = 1'b1;
        rs2_sel_d   = 1'b1;
        rd_in_sel_d = 2'b10;
        writes_d    = 1'b1;
        alu_op_d    = alu_decode(funct3, instr[30]);
      end
      OPC_OP_IMM: begin
        imm_d       = imm_i;
        rs1_sel_d   = 1'b1;
        rd_in_sel_d = 2'b10;
        writes_d    = 1'b1;
        // instr[30] is an immediate bit for ADDI; it only selects SRAI.
        alu_op_d    = alu_decode(funct3, (funct3 == 3'b101) & instr[30]);
      end
      OPC_LUI: begin
        imm_d       = imm_u;
        rd_in_sel_d = 2'b01;
        writes_d    = 1'b1;
      end
      OPC_AUIPC: begin
        imm_d       = imm_u;
        rd_in_sel_d = 2'b10;
        writes_d    = 1'b1;
      end
      OPC_JAL: begin
        imm_d    = imm_j;
        writes_d = 1'b1;
        is_jal_d = 1'b1;
      end
      OPC_JALR: begin
        imm_d       = imm_i;
        rs1_sel_d   = 1'b1;
        writes_d    = 1'b1;
        pc_in_sel_d = 1'b0;
      end
      OPC_BRANCH: begin
        imm_d       = imm_b;
        rs1_sel_d   = 1'b1;
        rs2_sel_d   = 1'b1;
        is_branch_d = 1'b1;
        alu_op_d    = ALU_SUB;
      end
      OPC_LOAD: begin
        imm_d     = imm_i;
        illegal_d = 1'b1;
      end
      OPC_STORE: begin
        imm_d     = imm_s;
        illegal_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_idx      <= 5'b0;
      rs1_idx     <= 5'b0;
      rs2_idx     <= 5'b0;
      imm         <= 32'b0;
      rs1_sel     <= 1'b0;
      rs2_sel     <= 1'b0;
      rd_in_sel   <= 2'b00;
      writes_q    <= 1'b0;
      pc_in_sel   <= 1'b0;
      is_branch_q <= 1'b0;
      is_jal_q    <= 1'b0;
      illegal     <= 1'b0;
      funct3_q    <= 3'b0;
      alu_op_q    <= ALU_ADD;
    end else if (ce && dec_en) begin
      rd_idx      <= instr[11:7];
      rs1_idx     <= instr[19:15];
      rs2_idx     <= instr[24:20];
      imm         <= imm_d;
      rs1_sel     <= rs1_sel_d;
      rs2_sel     <= rs2_sel_d;
      rd_in_sel   <= rd_in_sel_d;
      writes_q    <= writes_d;
      pc_in_sel   <= pc_in_sel_d;
      is_branch_q <= is_branch_d;
      is_jal_q    <= is_jal_d;
      illegal     <= illegal_d;
      funct3_q    <= funct3;
      alu_op_q    <= alu_op_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] op1, op2, alu_res_d;
  logic [4:0]  shamt;
  logic        lt, ltu;

  assign op1   = rs1_sel ? rs1_val : pc;
  assign op2   = rs2_sel ? rs2_val : imm;
  assign shamt = op2[4:0];
  assign lt    = $signed(op1) < $signed(op2);
  assign ltu   = op1 < op2;

  always_comb begin
    alu_res_d = 32'b0;
    case (alu_op_q)
      ALU_ADD:  alu_res_d = op1 + op2;
      ALU_SUB:  alu_res_d = op1 - op2;
      ALU_SLL:  alu_res_d = op1 << shamt;
      ALU_SLT:  alu_res_d = {31'b0, lt};
      ALU_SLTU: alu_res_d = {31'b0, ltu};
      ALU_XOR:  alu_res_d = op1 ^ op2;
      ALU_SRL:  alu_res_d = op1 >> shamt;
      ALU_SRA:  alu_res_d = $unsigned($signed(op1) >>> shamt);
      ALU_OR:   alu_res_d = op1 | op2;
      ALU_AND:  alu_res_d = op1 & op2;
      default:  alu_res_d = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result <= 32'b0;
      alu_flags  <= 3'b0;
    end else if (ce && alu_en) begin
      alu_result <= alu_res_d;
      alu_flags  <= {ltu, lt, (alu_res_d == 32'b0)};
    end
  end

  // ---------------------------------------------------------------------------
  // Branch resolution from registered flags
  // ---------------------------------------------------------------------------
  logic br_cond;

  always_comb begin
    br_cond = 1'b0;
    case (funct3_q)
      3'b000:  br_cond = alu_flags[0];
      3'b001:  br_cond = ~alu_flags[0];
      3'b100:  br_cond = alu_flags[1];
      3'b101:  br_cond = ~alu_flags[1];
      3'b110:  br_cond = alu_flags[2];
      3'b111:  br_cond = ~alu_flags[2];
      default: br_cond = 1'b0;
    endcase
  end

  assign branch_taken = is_jal_q | (is_branch_q & br_cond);

endmodule

// File: tb/tb_rv32i_ctl_exec.sv
module tb_rv32i_ctl_exec;

  logic        clk = 1'b0;
  logic        reset, ce;
  logic [31:0] instr, pc, rs1_val, rs2_val;
  logic        fetch_en, pc_inc, pc_in_sel, branch_taken, regfile_ce, regfile_we;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm;
  logic        rs1_sel, rs2_sel;
  logic [1:0]  rd_in_sel;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  rv32i_ctl_exec dut (
    .clk(clk), .reset(reset), .ce(ce), .instr(instr), .pc(pc),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .fetch_en(fetch_en), .pc_inc(pc_inc),
    .pc_in_sel(pc_in_sel), .branch_taken(branch_taken), .regfile_ce(regfile_ce),
    .regfile_we(regfile_we), .rd_idx(rd_idx), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .imm(imm), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_in_sel(rd_in_sel),
    .alu_result(alu_result), .alu_flags(alu_flags), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111,
                         BR = 7'b1100011;

  // Expected architectural behaviour of one instruction.
  typedef struct packed {
    logic        ill;
    logic        wr;
    logic        pcsel;
    logic        taken;
    logic        rdsel_chk;
    logic [1:0]  rdsel;
    logic        sel_chk;
    logic        r1s;
    logic        r2s;
    logic        alu_chk;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  // Snapshot of the last instruction, for directed constant checks.
  logic [31:0] s_res, s_imm;
  logic [2:0]  s_flags;
  logic        s_we, s_taken, s_pcsel;
  logic [1:0]  s_rdsel;
  logic [4:0]  s_rd;

  // Instruction encoders: the bench chooses an immediate and builds the word.
  function automatic logic [31:0] enc_r(input logic alt, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {1'b0, alt, 5'b0, rs2, rs1, f3, rd, OP};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] iv, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {iv[11:0], rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] iv, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3);
    return {iv[12], iv[10:5], rs2, rs1, f3, iv[4:1], iv[11], BR};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] iv, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {iv[31:12], rd, opc};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] iv, input logic [4:0] rd);
    return {iv[20], iv[10:1], iv[11], iv[19:12], rd, JAL};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic sub, input logic sra,
                                          input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (f3)
      3'd0: return sub ? a - b : a + b;
      3'd1: return a << s;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (a >> s) | ((sra && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] iv,
                                 input logic [31:0] pcv, input logic [31:0] r1,
                                 input logic [31:0] r2);
    exp_t e;
    logic [31:0] a, b;
    logic [2:0]  f3;
    f3 = ins[14:12];
    e = '0;
    e.pcsel = 1'b1;
    a = 32'd0;
    b = 32'd0;
    case (ins[6:0])
      OP: begin
        a = r1; b = r2;
        e.res = alu_ref(f3, ins[30] && f3 == 3'd0, ins[30] && f3 == 3'd5, a, b);
        e.wr = 1; e.rdsel_chk = 1; e.rdsel = 2'b10; e.sel_chk = 1; e.r1s = 1; e.r2s = 1;
        e.alu_chk = 1;
      end
      OPI: begin
        a = r1; b = iv;
        e.res = alu_ref(f3, 1'b0, ins[30] && f3 == 3'd5, a, b);
        e.wr = 1; e.rdsel_chk = 1; e.rdsel = 2'b10; e.sel_chk = 1; e.r1s = 1; e.alu_chk = 1;
      end
      LUI: begin
        e.wr = 1; e.rdsel_chk = 1; e.rdsel = 2'b01;
      end
      AUIPC: begin
        a = pcv; b = iv; e.res = a + b;
        e.wr = 1; e.rdsel_chk = 1; e.rdsel = 2'b10; e.sel_chk = 1; e.alu_chk = 1;
      end
      JAL: begin
        e.wr = 1; e.rdsel_chk = 1; e.rdsel = 2'b00; e.taken = 1;
      end
      JALR: begin
        a = r1; b = iv; e.res = a + b;
        e.wr = 1; e.rdsel_chk = 1; e.rdsel = 2'b00; e.pcsel = 0; e.sel_chk = 1; e.r1s = 1;
        e.alu_chk = 1;
      end
      BR: begin
        a = r1; b = r2; e.res = a - b;
        e.sel_chk = 1; e.r1s = 1; e.r2s = 1; e.alu_chk = 1;
        case (f3)
          3'd0: e.taken = (a == b);
          3'd1: e.taken = (a != b);
          3'd4: e.taken = ($signed(a) < $signed(b));
          3'd5: e.taken = !($signed(a) < $signed(b));
          3'd6: e.taken = (a < b);
          3'd7: e.taken = !(a < b);
          default: e.taken = 0;
        endcase
      end
      default: e.ill = 1;
    endcase
    e.flg = {a < b, $signed(a) < $signed(b), e.res == 32'd0};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH through WRITEBACK; ends back in FETCH.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [31:0] iv,
                           input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e = model(ins, iv, pcv, r1, r2);
    instr = ins; pc = pcv; rs1_val = r1; rs2_val = r2;
    #1;
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we} !== 4'b1000) begin
      errors++; $display("FAIL %s fetch strobes got %b want 1000", tag, {fetch_en, regfile_ce, pc_inc, regfile_we});
    end
    tick();
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we} !== 4'b0100) begin
      errors++; $display("FAIL %s decode strobes got %b want 0100", tag, {fetch_en, regfile_ce, pc_inc, regfile_we});
    end
    tick();
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we} !== 4'b0000) begin
      errors++; $display("FAIL %s execute strobes got %b want 0000", tag, {fetch_en, regfile_ce, pc_inc, regfile_we});
    end
    checks++;
    if ({rd_idx, rs1_idx, rs2_idx} !== {ins[11:7], ins[19:15], ins[24:20]}) begin
      errors++; $display("FAIL %s indices got %h want %h", tag, {rd_idx, rs1_idx, rs2_idx}, {ins[11:7], ins[19:15], ins[24:20]});
    end
    checks++;
    if (illegal !== e.ill) begin
      errors++; $display("FAIL %s illegal got %b want %b", tag, illegal, e.ill);
    end
    if (!e.ill) begin
      checks++;
      if (imm !== iv) begin
        errors++; $display("FAIL %s imm got %h want %h", tag, imm, iv);
      end
    end
    if (e.sel_chk) begin
      checks++;
      if ({rs1_sel, rs2_sel} !== {e.r1s, e.r2s}) begin
        errors++; $display("FAIL %s selects got %b want %b", tag, {rs1_sel, rs2_sel}, {e.r1s, e.r2s});
      end
    end
    s_imm = imm; s_rd = rd_idx;
    tick();
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we} !== {3'b011, e.wr}) begin
      errors++; $display("FAIL %s writeback strobes got %b want %b", tag, {fetch_en, regfile_ce, pc_inc, regfile_we}, {3'b011, e.wr});
    end
    checks++;
    if ({pc_in_sel, branch_taken} !== {e.pcsel, e.taken}) begin
      errors++; $display("FAIL %s pc_in_sel/taken got %b want %b", tag, {pc_in_sel, branch_taken}, {e.pcsel, e.taken});
    end
    if (e.rdsel_chk) begin
      checks++;
      if (rd_in_sel !== e.rdsel) begin
        errors++; $display("FAIL %s rd_in_sel got %b want %b", tag, rd_in_sel, e.rdsel);
      end
    end
    if (e.alu_chk) begin
      checks++;
      if ({alu_result, alu_flags} !== {e.res, e.flg}) begin
        errors++; $display("FAIL %s alu got %h/%b want %h/%b", tag, alu_result, alu_flags, e.res, e.flg);
      end
    end
    s_res = alu_result; s_flags = alu_flags; s_we = regfile_we; s_taken = branch_taken;
    s_pcsel = pc_in_sel; s_rdsel = rd_in_sel;
    tick();
  endtask

  task automatic test_reset();
    reset = 1; ce = 1; instr = 32'h0; pc = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
    tick(); tick();
    reset = 0;
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we} !== 4'b1000) begin
      errors++; $display("FAIL reset strobes got %b want 1000", {fetch_en, regfile_ce, pc_inc, regfile_we});
    end
    checks++;
    if ({imm, alu_result, alu_flags, rd_idx, rs1_idx, rs2_idx} !== '0) begin
      errors++; $display("FAIL reset regs got imm=%h alu=%h flags=%b idx=%h", imm, alu_result, alu_flags, {rd_idx, rs1_idx, rs2_idx});
    end
    checks++;
    if ({rs1_sel, rs2_sel, rd_in_sel, pc_in_sel, branch_taken, illegal} !== 7'b0) begin
      errors++; $display("FAIL reset selects got %b want 0000000", {rs1_sel, rs2_sel, rd_in_sel, pc_in_sel, branch_taken, illegal});
    end
  endtask

  task automatic test_addi();
    run_instr("addi", 32'h00500093, 32'd5, 32'h100, 32'd0, 32'd0);
    checks++;
    if ({s_imm, s_rd, s_res, s_rdsel, s_we} !== {32'd5, 5'd1, 32'd5, 2'b10, 1'b1}) begin
      errors++; $display("FAIL addi_plan got imm=%h rd=%0d res=%h rdsel=%b we=%b", s_imm, s_rd, s_res, s_rdsel, s_we);
    end
  endtask

  task automatic test_sub();
    run_instr("sub", 32'h402081B3, 32'd0, 32'h104, 32'd3, 32'd5);
    checks++;
    if ({s_res, s_flags} !== {32'hFFFF_FFFE, 3'b110}) begin
      errors++; $display("FAIL sub_plan got %h/%b want fffffffe/110", s_res, s_flags);
    end
  endtask

  task automatic test_beq();
    run_instr("beq", 32'h00208463, 32'd8, 32'h108, 32'h1234, 32'h1234);
    checks++;
    if ({s_taken, s_pcsel, s_imm, s_we} !== {1'b1, 1'b1, 32'd8, 1'b0}) begin
      errors++; $display("FAIL beq_plan got taken=%b pcsel=%b imm=%h we=%b", s_taken, s_pcsel, s_imm, s_we);
    end
  endtask

  task automatic test_bltu_blt();
    run_instr("bltu", enc_b(32'd16, 5'd2, 5'd1, 3'd6), 32'd16, 32'h10C, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if ({s_flags[2], s_taken} !== 2'b00) begin
      errors++; $display("FAIL bltu_plan got ltu=%b taken=%b want 0 0", s_flags[2], s_taken);
    end
    run_instr("blt", enc_b(32'd16, 5'd2, 5'd1, 3'd4), 32'd16, 32'h110, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (s_taken !== 1'b1) begin
      errors++; $display("FAIL blt_plan got taken=%b want 1", s_taken);
    end
  endtask

  task automatic test_jalr();
    run_instr("jalr", enc_i(32'd8, 5'd2, 3'd0, 5'd1, JALR), 32'd8, 32'h114, 32'h101, $urandom);
    checks++;
    if ({s_pcsel, s_res, s_rdsel, s_we} !== {1'b0, 32'h109, 2'b00, 1'b1}) begin
      errors++; $display("FAIL jalr_plan got pcsel=%b res=%h rdsel=%b we=%b", s_pcsel, s_res, s_rdsel, s_we);
    end
  endtask

  task automatic test_ce_hold_reset();
    logic [31:0] prev;
    prev = alu_result;
    instr = enc_i(32'h7F, 5'd3, 3'd0, 5'd5, OPI); rs1_val = 32'h10; pc = 32'h200;
    tick(); tick();
    ce = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({fetch_en, regfile_ce, pc_inc, regfile_we, alu_result} !== {4'b0000, prev}) begin
        errors++; $display("FAIL ce_hold cycle %0d got strobes=%b alu=%h want 0000/%h", i, {fetch_en, regfile_ce, pc_inc, regfile_we}, alu_result, prev);
      end
    end
    ce = 1;
    tick();
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we, alu_result} !== {4'b0111, 32'h8F}) begin
      errors++; $display("FAIL ce_resume got strobes=%b alu=%h want 0111/0000008f", {fetch_en, regfile_ce, pc_inc, regfile_we}, alu_result);
    end
    reset = 1;
    #1;
    checks++;
    if ({pc_inc, regfile_we} !== 2'b00) begin
      errors++; $display("FAIL wb_abort got pc_inc/we=%b want 00", {pc_inc, regfile_we});
    end
    tick();
    reset = 0;
    #1;
    checks++;
    if ({fetch_en, regfile_ce, pc_inc, regfile_we, alu_result, imm} !== {4'b1000, 64'd0}) begin
      errors++; $display("FAIL after_abort got strobes=%b alu=%h imm=%h", {fetch_en, regfile_ce, pc_inc, regfile_we}, alu_result, imm);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, iv, r1, r2, pcv;
    logic [2:0]  f3;
    logic [4:0]  rd, s1, s2;
    logic        alt;
    logic [6:0]  bad [5];
    bad[0] = 7'b0000011; bad[1] = 7'b0100011; bad[2] = 7'b0001111;
    bad[3] = 7'b1110011; bad[4] = 7'b0000000;
    for (int n = 0; n < 120; n++) begin
      rd = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom); f3 = 3'($urandom);
      r1 = $urandom; r2 = $urandom; pcv = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 3) == 0) r1 = 32'($urandom_range(0, 40)) - 32'd20;
      iv = 32'd0;
      case ($urandom_range(0, 7))
        0: begin
          alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom) : 1'b0;
          ins = enc_r(alt, s2, s1, f3, rd);
        end
        1: begin
          if (f3 == 3'd1) iv = 32'($urandom_range(0, 31));
          else if (f3 == 3'd5) iv = 32'($urandom_range(0, 31)) + ($urandom_range(0, 1) ? 32'h400 : 32'h0);
          else iv = 32'($urandom_range(0, 4095)) - 32'd2048;
          ins = enc_i(iv, s1, f3, rd, OPI);
        end
        2: begin iv = {$urandom_range(0, 32'hFFFFF), 12'h000}; ins = enc_u(iv, rd, LUI); end
        3: begin iv = {$urandom_range(0, 32'hFFFFF), 12'h000}; ins = enc_u(iv, rd, AUIPC); end
        4: begin iv = 2 * (32'($urandom_range(0, 32'hFFFFF)) - 32'h80000); ins = enc_j(iv, rd); end
        5: begin iv = 32'($urandom_range(0, 4095)) - 32'd2048; ins = enc_i(iv, s1, 3'd0, rd, JALR); end
        6: begin
          iv = 2 * (32'($urandom_range(0, 4095)) - 32'd2048);
          if ($urandom_range(0, 2) == 0) r2 = r1;
          ins = enc_b(iv, s2, s1, f3);
        end
        default: ins = {$urandom_range(0, 32'h1FFFFFF), bad[$urandom_range(0, 4)]};
      endcase
      run_instr("random", ins, iv, pcv, r1, r2);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub();
    test_beq();
    test_bltu_blt();
    test_jalr();
    test_ce_hold_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
